// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings, multdiv FSM states and the X-stage control bundle
// for the pipelined control unit (ctrl_pipe / ctrl_decode).
package ctrl_pkg;

  // Primary opcodes
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  // R-type ALU-op values with special meaning; everything else passes through the ALU
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } md_state_t;

  // Full bundle as produced by decode and held in X
  typedef struct packed {
    logic aluinb;
    logic sub;
    logic br_ne;
    logic br_lt;
    logic jp;
    logic jr;
    logic md;
    logic md_div;
    logic dmwe;
    logic rwe;
    logic rdst;
    logic rwd;
    logic link;
  } ctrl_t;

  // Subsets still needed once the instruction leaves X
  typedef struct packed {
    logic dmwe;
    logic rwe;
    logic rdst;
    logic rwd;
    logic link;
  } m_ctrl_t;

  typedef struct packed {
    logic rwe;
    logic rdst;
    logic rwd;
    logic link;
  } w_ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/aluop -> control bundle plus illegal flag.
// Build option CTRL_MULTDIV_EN: when defined, R-type mul/div decode to md=1;
// otherwise they are reported illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] aluop,
  output ctrl_t          ctl,
  output logic           illegal
);

  logic is_mul, is_div;

  assign is_mul = (aluop == OPW'(ALU_MUL));
  assign is_div = (aluop == OPW'(ALU_DIV));

  // Decode; an illegal opcode leaves every enable at 0
  always_comb begin
    ctl     = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OPW'(OP_R): begin
        if (is_mul || is_div) begin
`ifdef CTRL_MULTDIV_EN
          ctl.md     = 1'b1;
          ctl.md_div = is_div;
          ctl.rwe    = 1'b1;
          ctl.rdst   = 1'b1;
`else
          illegal    = 1'b1;
`endif
        end else begin
          ctl.rwe  = 1'b1;
          ctl.rdst = 1'b1;
          ctl.sub  = (aluop == OPW'(ALU_SUB));
        end
      end
      OPW'(OP_J):    ctl.jp = 1'b1;
      OPW'(OP_BNE):  begin ctl.br_ne = 1'b1; ctl.sub = 1'b1; end
      OPW'(OP_JAL):  begin ctl.jp = 1'b1; ctl.rwe = 1'b1; ctl.link = 1'b1; end
      OPW'(OP_JR):   ctl.jr = 1'b1;
      OPW'(OP_ADDI): begin ctl.aluinb = 1'b1; ctl.rwe = 1'b1; end
      OPW'(OP_BLT):  begin ctl.br_lt = 1'b1; ctl.sub = 1'b1; end
      OPW'(OP_SW):   begin ctl.aluinb = 1'b1; ctl.dmwe = 1'b1; end
      OPW'(OP_LW):   begin ctl.aluinb = 1'b1; ctl.rwe = 1'b1; ctl.rwd = 1'b1; end
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode + X/M/W control pipeline with bubbles, flush, and the
// multdiv start/wait handshake that freezes D and X.
// Build option CTRL_MULTDIV_EN: when undefined the multdiv FSM, counter and
// timeout are not built; md_start, md_is_div, err_md_timeout are tied 0.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int MD_MAX = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] d_opcode,
  input  logic [OPW-1:0] d_aluop,
  input  logic           d_valid,
  input  logic           hazard_stall,
  input  logic           flush,
  input  logic           md_ready,
  output logic           x_valid,
  output logic           x_aluinb,
  output logic           x_sub,
  output logic           x_br_ne,
  output logic           x_br_lt,
  output logic           x_jp,
  output logic           x_jr,
  output logic           x_md,
  output logic           m_valid,
  output logic           m_dmwe,
  output logic           w_valid,
  output logic           w_rwe,
  output logic           w_rdst,
  output logic           w_rwd,
  output logic           w_link,
  output logic           md_start,
  output logic           md_is_div,
  output logic           stall_fd,
  output logic           err_illegal,
  output logic           err_md_timeout
);

  ctrl_t   dec_ctl;
  logic    dec_illegal;

  logic    x_v, m_v, w_v;
  ctrl_t   x_c;
  m_ctrl_t m_c;
  w_ctrl_t w_c;

  logic    md_hold;   // FSM in START or WAIT
  logic    md_begin;  // md op sitting in X with FSM idle
  logic    md_tmo;    // last allowed WAIT cycle without a result
  logic    md_done;   // X releases on this edge
  logic    x_freeze;
  logic    x_bubble;
  logic    m_load;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .opcode  (d_opcode),
    .aluop   (d_aluop),
    .ctl     (dec_ctl),
    .illegal (dec_illegal)
  );

`ifdef CTRL_MULTDIV_EN
  localparam int CW = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;

  md_state_t     state;
  logic [CW-1:0] md_cnt;

  assign md_hold  = (state != MD_IDLE);
  assign md_begin = (state == MD_IDLE) && x_v && x_c.md;
  assign md_tmo   = (state == MD_WAIT) && !md_ready && (md_cnt == CW'(MD_MAX - 1));
  assign md_done  = md_hold && (md_ready || md_tmo);

  // Multdiv handshake: pulse start, wait for ready or give up after MD_MAX WAIT cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= MD_IDLE;
      md_cnt         <= '0;
      md_start       <= 1'b0;
      md_is_div      <= 1'b0;
      err_md_timeout <= 1'b0;
    end else begin
      md_start  <= 1'b0;
      md_is_div <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (md_begin) begin
            state     <= MD_START;
            md_start  <= 1'b1;
            md_is_div <= x_c.md_div;
          end
        end
        MD_START: begin
          md_cnt <= '0;
          state  <= md_ready ? MD_IDLE : MD_WAIT;
        end
        MD_WAIT: begin
          if (md_ready) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
          end else if (md_tmo) begin
            state          <= MD_IDLE;
            md_cnt         <= '0;
            err_md_timeout <= 1'b1;
          end else begin
            md_cnt <= md_cnt + CW'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
`else
  logic unused_md;

  assign md_hold        = 1'b0;
  assign md_begin       = 1'b0;
  assign md_tmo         = 1'b0;
  assign md_done        = 1'b0;
  assign md_start       = 1'b0;
  assign md_is_div      = 1'b0;
  assign err_md_timeout = 1'b0;
  assign unused_md      = ^{md_ready, x_c.md_div};
`endif

  // X holds the md op from the cycle it is seen until the release edge.
  // While D is frozen by the multdiv, X only ever takes bubbles so the
  // instruction parked in D is not duplicated.
  assign x_freeze = md_begin | (md_hold & ~md_done);
  assign x_bubble = md_hold | hazard_stall | (flush & ~md_hold) | ~d_valid;
  // A timed-out op has no valid result, so it is dropped instead of written back
  assign m_load   = ~x_freeze & ~md_tmo;
  assign stall_fd = hazard_stall | md_hold | md_begin;

  // X stage: hold, take a bubble, or take the decoded instruction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_v         <= 1'b0;
      x_c         <= CTRL_NOP;
      err_illegal <= 1'b0;
    end else if (!x_freeze) begin
      if (x_bubble) begin
        x_v <= 1'b0;
        x_c <= CTRL_NOP;
      end else begin
        x_v <= 1'b1;
        x_c <= dec_ctl;
        if (dec_illegal) err_illegal <= 1'b1;
      end
    end
  end

  // M stage: takes X, or a bubble while X is held by the multdiv
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_v <= 1'b0;
      m_c <= '0;
    end else if (m_load) begin
      m_v <= x_v;
      m_c <= '{dmwe: x_c.dmwe, rwe: x_c.rwe, rdst: x_c.rdst, rwd: x_c.rwd, link: x_c.link};
    end else begin
      m_v <= 1'b0;
      m_c <= '0;
    end
  end

  // W stage: always advances
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_v <= 1'b0;
      w_c <= '0;
    end else begin
      w_v <= m_v;
      w_c <= '{rwe: m_c.rwe, rdst: m_c.rdst, rwd: m_c.rwd, link: m_c.link};
    end
  end

  assign x_valid  = x_v;
  assign x_aluinb = x_v & x_c.aluinb;
  assign x_sub    = x_v & x_c.sub;
  assign x_br_ne  = x_v & x_c.br_ne;
  assign x_br_lt  = x_v & x_c.br_lt;
  assign x_jp     = x_v & x_c.jp;
  assign x_jr     = x_v & x_c.jr;
  assign x_md     = x_v & x_c.md;
  assign m_valid  = m_v;
  assign m_dmwe   = m_v & m_c.dmwe;
  assign w_valid  = w_v;
  assign w_rwe    = w_v & w_c.rwe;
  assign w_rdst   = w_v & w_c.rdst;
  assign w_rwd    = w_v & w_c.rwd;
  assign w_link   = w_v & w_c.link;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed test-plan sequences plus randomized traffic, checked
// against an instruction-level reference model of where each instruction sits.
module tb_ctrl_pipe;

  localparam int MD_MAX = 8;
`ifdef CTRL_MULTDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] d_opcode = '0, d_aluop = '0;
  logic d_valid = 1'b0, hazard_stall = 1'b0, flush = 1'b0, md_ready = 1'b0;
  logic x_valid, x_aluinb, x_sub, x_br_ne, x_br_lt, x_jp, x_jr, x_md;
  logic m_valid, m_dmwe, w_valid, w_rwe, w_rdst, w_rwd, w_link;
  logic md_start, md_is_div, stall_fd, err_illegal, err_md_timeout;

  always #5 clock = ~clock;

  ctrl_pipe #(.OPW(5), .MD_MAX(MD_MAX)) dut (
    .clock(clock), .reset(reset), .d_opcode(d_opcode), .d_aluop(d_aluop),
    .d_valid(d_valid), .hazard_stall(hazard_stall), .flush(flush), .md_ready(md_ready),
    .x_valid(x_valid), .x_aluinb(x_aluinb), .x_sub(x_sub), .x_br_ne(x_br_ne),
    .x_br_lt(x_br_lt), .x_jp(x_jp), .x_jr(x_jr), .x_md(x_md),
    .m_valid(m_valid), .m_dmwe(m_dmwe), .w_valid(w_valid), .w_rwe(w_rwe),
    .w_rdst(w_rdst), .w_rwd(w_rwd), .w_link(w_link), .md_start(md_start),
    .md_is_div(md_is_div), .stall_fd(stall_fd), .err_illegal(err_illegal),
    .err_md_timeout(err_md_timeout)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic v; logic [4:0] op; logic [4:0] alu; } ins_t;
  typedef struct packed {
    bit aluinb, sub, br_ne, br_lt, jp, jr, md, dmwe, rwe, rdst, rwd, link;
  } tctl_t;

  ins_t mx, mm, mw;          // instruction currently in X, M, W
  int   ph;                  // 0 idle, 1 start, 2 wait
  int   waited;              // WAIT cycles spent so far
  bit   e_ill, e_tmo, e_start, e_div;

  function automatic bit is_md(ins_t i);
    return i.op == 5'd0 && (i.alu == 5'd6 || i.alu == 5'd7);
  endfunction

  function automatic bit legal(ins_t i);
    return (i.op <= 5'd8) && !(is_md(i) && !MD_EN);
  endfunction

  // Control meaning of one instruction, straight from the encoding table
  function automatic tctl_t spec_ctl(ins_t i);
    tctl_t c = '0;
    bit r = (i.op == 5'd0);
    if (!i.v || !legal(i)) return c;
    c.aluinb = (i.op == 5'd5) || (i.op == 5'd7) || (i.op == 5'd8);
    c.sub    = (r && i.alu == 5'd1) || (i.op == 5'd2) || (i.op == 5'd6);
    c.br_ne  = (i.op == 5'd2);
    c.br_lt  = (i.op == 5'd6);
    c.jp     = (i.op == 5'd1) || (i.op == 5'd3);
    c.jr     = (i.op == 5'd4);
    c.md     = is_md(i);
    c.dmwe   = (i.op == 5'd7);
    c.rwe    = r || (i.op == 5'd5) || (i.op == 5'd8) || (i.op == 5'd3);
    c.rdst   = r;
    c.rwd    = (i.op == 5'd8);
    c.link   = (i.op == 5'd3);
    return c;
  endfunction

  task automatic model_reset();
    mx = '0; mm = '0; mw = '0; ph = 0; waited = 0;
    e_ill = 0; e_tmo = 0; e_start = 0; e_div = 0;
  endtask

  task automatic check_outputs(input string tag);
    tctl_t cx = spec_ctl(mx), cm = spec_ctl(mm), cw = spec_ctl(mw);
    chk({tag, ".x"}, 32'({x_valid, x_aluinb, x_sub, x_br_ne, x_br_lt, x_jp, x_jr, x_md}),
        32'({mx.v, cx.aluinb, cx.sub, cx.br_ne, cx.br_lt, cx.jp, cx.jr, cx.md}));
    chk({tag, ".m"}, 32'({m_valid, m_dmwe}), 32'({mm.v, cm.dmwe}));
    chk({tag, ".w"}, 32'({w_valid, w_rwe, w_rdst, w_rwd, w_link}),
        32'({mw.v, cw.rwe, cw.rdst, cw.rwd, cw.link}));
    chk({tag, ".flags"}, 32'({md_start, md_is_div, err_illegal, err_md_timeout}),
        32'({e_start, e_div, e_ill, e_tmo}));
  endtask

  // One clock: apply inputs, check the combinational stall, advance model and DUT
  task automatic cyc(input string tag, input bit dv, input logic [4:0] op, input logic [4:0] alu,
                     input bit hz, input bit fl, input bit rdy);
    ins_t d, nx, nm;
    bit hold, beg, tmo, done, park;
    d_valid = dv; d_opcode = op; d_aluop = alu;
    hazard_stall = hz; flush = fl; md_ready = rdy;
    #1;
    hold = (ph != 0);
    beg  = !hold && MD_EN && mx.v && is_md(mx);
    chk({tag, ".stall"}, 32'(stall_fd), 32'(hz || hold || beg));
    tmo  = (ph == 2) && !rdy && (waited == MD_MAX - 1);
    done = hold && (rdy || tmo);
    park = beg || (hold && !done);          // md op stays in X
    d    = '{v: dv, op: op, alu: alu};
    nm   = (park || tmo) ? ins_t'('0) : mx;
    if (park)                         nx = mx;
    else if (hold || hz || fl || !dv) nx = '0;
    else                              nx = d;
    @(posedge clock);
    mw = mm; mm = nm; mx = nx;
    if (!park && nx.v && !legal(nx)) e_ill = 1;
    e_start = 0; e_div = 0;
    if (beg) begin
      ph = 1; e_start = 1; e_div = (mw.v === 1'bx) ? 0 : (nx.alu == 5'd7);
    end else if (ph == 1) begin
      ph = rdy ? 0 : 2; waited = 0;
    end else if (ph == 2) begin
      if (rdy) begin ph = 0; waited = 0; end
      else if (tmo) begin ph = 0; waited = 0; e_tmo = 1; end
      else waited++;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic nop(input string tag, input bit rdy);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic mid_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".stall"}, 32'(stall_fd), 32'(hazard_stall));
    #3;
    reset = 1'b0;
  endtask

  logic [4:0] rop, ralu;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_outputs("post_reset");

    // addi, sw, lw, add back to back
    cyc("stream_addi", 1, 5'd5, 5'd0, 0, 0, 0);
    cyc("stream_sw",   1, 5'd7, 5'd0, 0, 0, 0);
    cyc("stream_lw",   1, 5'd8, 5'd0, 0, 0, 0);
    cyc("stream_add",  1, 5'd0, 5'd0, 0, 0, 0);
    repeat (4) nop("stream_drain", 0);

    // lw then a one-cycle load-use hazard
    cyc("lu_lw",  1, 5'd8, 5'd0, 0, 0, 0);
    cyc("lu_haz", 1, 5'd0, 5'd1, 1, 0, 0);
    cyc("lu_go",  1, 5'd0, 5'd1, 0, 0, 0);
    repeat (3) nop("lu_drain", 0);

    // bne in X, then flush together with hazard_stall
    cyc("fl_bne", 1, 5'd2, 5'd0, 0, 0, 0);
    cyc("fl_kill", 1, 5'd1, 5'd0, 1, 1, 0);
    repeat (3) nop("fl_drain", 0);

    // mul with md_ready four cycles after md_start
    cyc("mul_issue", 1, 5'd0, 5'd6, 0, 0, 0);
    for (int i = 0; i < 10; i++) nop("mul_wait", i == 5);
    // div with no md_ready: timeout path
    cyc("div_issue", 1, 5'd0, 5'd7, 0, 0, 0);
    for (int i = 0; i < 14; i++) nop("div_wait", 0);
    cyc("div_resume", 1, 5'd5, 5'd0, 0, 0, 0);
    repeat (3) nop("div_drain", 0);

    // illegal opcode through to W, then div and a reset while waiting
    cyc("ill_op", 1, 5'b11111, 5'd0, 0, 0, 0);
    repeat (3) nop("ill_drain", 0);
    cyc("rst_div", 1, 5'd0, 5'd7, 0, 0, 0);
    repeat (4) nop("rst_wait", 0);
    mid_reset("rst_mid");
    repeat (3) nop("rst_after", 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(0, 12);
      rop = (k <= 8) ? 5'(k) : (k <= 10) ? 5'd0 : 5'($urandom_range(9, 31));
      case ($urandom_range(0, 4))
        0: ralu = 5'd0;
        1: ralu = 5'd1;
        2: ralu = 5'd6;
        3: ralu = 5'd7;
        default: ralu = 5'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 199) == 0) mid_reset("rnd_reset");
      else cyc("rnd", $urandom_range(0, 99) < 85, rop, ralu,
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
